// File: rtl/bullet_pool_pkg.sv
// Shared parameters and types for the player bullet pool.
package bullet_pool_pkg;

  localparam int unsigned DEF_HRES            = 1280;
  localparam int unsigned DEF_VRES            = 720;
  localparam int unsigned DEF_BULLET_W        = 4;
  localparam int unsigned DEF_BULLET_H        = 16;
  localparam int unsigned DEF_BULLET_SPEED    = 16;
  localparam int unsigned DEF_N_BULLETS       = 4;
  localparam int unsigned DEF_COOLDOWN_FRAMES = 8;

  // Per-cycle update applied to one bullet slot.
  typedef enum logic [1:0] {
    SLOT_HOLD,
    SLOT_LOAD,
    SLOT_KILL,
    SLOT_MOVE
  } slot_op_t;

  // Slot index width, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bullet_pool_slot.sv
// One bullet slot: active/x/y registers, load/kill/move priority, pixel-hit compare.
module bullet_slot
  import bullet_pool_pkg::*;
#(
  parameter int unsigned X_W          = 11,
  parameter int unsigned Y_W          = 10,
  parameter int unsigned BULLET_W     = DEF_BULLET_W,
  parameter int unsigned BULLET_H     = DEF_BULLET_H,
  parameter int unsigned BULLET_SPEED = DEF_BULLET_SPEED
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           load,
  input  logic [X_W-1:0] load_x,
  input  logic [Y_W-1:0] load_y,
  input  logic           kill,
  input  logic [X_W-1:0] hcount,
  input  logic [Y_W-1:0] vcount,
  output logic           active,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           pix_hit
);

  slot_op_t     op;
  logic [X_W:0] x_end;
  logic [Y_W:0] y_end;

  // Choose this cycle's update; a load only targets a free slot, so it never races a live kill.
  always_comb begin
    op = SLOT_HOLD;
    if (load) begin
      op = SLOT_LOAD;
    end else if (kill) begin
      op = SLOT_KILL;
    end else if (tick && active) begin
      op = SLOT_MOVE;
    end
  end

  // Slot registers; a bullet about to cross the top edge retires instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      x      <= '0;
      y      <= '0;
    end else begin
      case (op)
        SLOT_LOAD: begin
          active <= 1'b1;
          x      <= load_x;
          y      <= load_y;
        end
        SLOT_KILL: active <= 1'b0;
        SLOT_MOVE: begin
          if (y < Y_W'(BULLET_SPEED)) begin
            active <= 1'b0;
          end else begin
            y <= y - Y_W'(BULLET_SPEED);
          end
        end
        default: ;
      endcase
    end
  end

  // Bullet rectangle test, one bit wider so the far-edge sums cannot overflow.
  always_comb begin
    x_end   = {1'b0, x} + (X_W+1)'(BULLET_W);
    y_end   = {1'b0, y} + (Y_W+1)'(BULLET_H);
    pix_hit = active
            && ({1'b0, hcount} >= {1'b0, x}) && ({1'b0, hcount} < x_end)
            && ({1'b0, vcount} >= {1'b0, y}) && ({1'b0, vcount} < y_end);
  end

endmodule

// File: rtl/bullet_pool.sv
// Pool of player bullets: slot allocation, shot cooldown, ack/drop pulses, pixel flag.
module bullet_pool
  import bullet_pool_pkg::*;
#(
  parameter  int unsigned N_BULLETS       = DEF_N_BULLETS,
  parameter  int unsigned HRES            = DEF_HRES,
  parameter  int unsigned VRES            = DEF_VRES,
  parameter  int unsigned BULLET_W        = DEF_BULLET_W,
  parameter  int unsigned BULLET_H        = DEF_BULLET_H,
  parameter  int unsigned BULLET_SPEED    = DEF_BULLET_SPEED,
  parameter  int unsigned COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
  parameter  int unsigned X_W             = $clog2(HRES),
  parameter  int unsigned Y_W             = $clog2(VRES),
  localparam int unsigned IDX_W           = idx_width(N_BULLETS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_tick,
  input  logic                     fire_req,
  input  logic [X_W-1:0]           fire_x,
  input  logic [Y_W-1:0]           fire_y,
  output logic                     fire_ack,
  output logic                     fire_drop,
  input  logic                     hit_valid,
  input  logic [IDX_W-1:0]         hit_idx,
  output logic [N_BULLETS-1:0]     active,
  output logic [N_BULLETS*X_W-1:0] bx,
  output logic [N_BULLETS*Y_W-1:0] by,
  input  logic [X_W-1:0]           hcount,
  input  logic [Y_W-1:0]           vcount,
  output logic                     pix_on
);

  localparam int unsigned    CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [X_W-1:0] X_MAX = X_W'(HRES - BULLET_W);

  logic [CD_W-1:0]      cooldown;
  logic                 any_free;
  logic [IDX_W-1:0]     free_idx;
  logic                 accept;
  logic                 refuse;
  logic [X_W-1:0]       spawn_x;
  logic [N_BULLETS-1:0] load;
  logic [N_BULLETS-1:0] kill;
  logic [N_BULLETS-1:0] pix_hit;

  // Lowest-index free slot: scanning from the top down lets the lowest index win.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < N_BULLETS; i++) begin
      if (!active[N_BULLETS-1-i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(N_BULLETS - 1 - i);
      end
    end
  end

  // Fire decision, spawn clamp and per-slot load/kill strobes.
  always_comb begin
    accept  = fire_req && (cooldown == '0) && any_free;
    refuse  = fire_req && (cooldown == '0) && !any_free;
    spawn_x = (fire_x > X_MAX) ? X_MAX : fire_x;
    load    = '0;
    kill    = '0;
    for (int unsigned i = 0; i < N_BULLETS; i++) begin
      load[i] = accept && (free_idx == IDX_W'(i));
      kill[i] = hit_valid && (hit_idx == IDX_W'(i));
    end
  end

  // Shot cooldown: reload on an accepted shot, otherwise count frames down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cooldown <= '0;
    end else if (accept) begin
      cooldown <= CD_W'(COOLDOWN_FRAMES);
    end else if (frame_tick && (cooldown != '0)) begin
      cooldown <= cooldown - CD_W'(1);
    end
  end

  // Registered handshake pulses and the pixel flag for the video mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      fire_ack  <= 1'b0;
      fire_drop <= 1'b0;
      pix_on    <= 1'b0;
    end else begin
      fire_ack  <= accept;
      fire_drop <= refuse;
      pix_on    <= |pix_hit;
    end
  end

  for (genvar g = 0; g < N_BULLETS; g++) begin : g_slot
    bullet_slot #(
      .X_W          (X_W),
      .Y_W          (Y_W),
      .BULLET_W     (BULLET_W),
      .BULLET_H     (BULLET_H),
      .BULLET_SPEED (BULLET_SPEED)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .tick    (frame_tick),
      .load    (load[g]),
      .load_x  (spawn_x),
      .load_y  (fire_y),
      .kill    (kill[g]),
      .hcount  (hcount),
      .vcount  (vcount),
      .active  (active[g]),
      .x       (bx[g*X_W +: X_W]),
      .y       (by[g*Y_W +: Y_W]),
      .pix_hit (pix_hit[g])
    );
  end

endmodule

// File: tb/tb_bullet_pool.sv
// Bench for bullet_pool: two pools (no cooldown / 8-frame cooldown) driven by shared
// inputs, checked every cycle against a behavioural model plus directed sequences.
module tb_bullet_pool;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        fire_req = 1'b0;
  logic        hit_valid = 1'b0;
  logic [10:0] fire_x = '0;
  logic [9:0]  fire_y = '0;
  logic [1:0]  hit_idx = '0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;

  logic        a_ack, a_drop, a_pix, b_ack, b_drop, b_pix;
  logic [3:0]  a_active, b_active;
  logic [43:0] a_bx, b_bx;
  logic [39:0] a_by, b_by;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bullet_pool #(.N_BULLETS(4), .COOLDOWN_FRAMES(0)) dut_a (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .fire_req(fire_req),
    .fire_x(fire_x), .fire_y(fire_y), .fire_ack(a_ack), .fire_drop(a_drop),
    .hit_valid(hit_valid), .hit_idx(hit_idx), .active(a_active), .bx(a_bx), .by(a_by),
    .hcount(hcount), .vcount(vcount), .pix_on(a_pix)
  );

  bullet_pool #(.N_BULLETS(4), .COOLDOWN_FRAMES(8)) dut_b (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .fire_req(fire_req),
    .fire_x(fire_x), .fire_y(fire_y), .fire_ack(b_ack), .fire_drop(b_drop),
    .hit_valid(hit_valid), .hit_idx(hit_idx), .active(b_active), .bx(b_bx), .by(b_by),
    .hcount(hcount), .vcount(vcount), .pix_on(b_pix)
  );

  // Reference model, index 0 = pool A, 1 = pool B.
  bit m_act [2][4];
  int m_x   [2][4];
  int m_y   [2][4];
  int m_cd  [2];
  bit m_ack [2];
  bit m_drop[2];
  bit m_pix [2];

  task automatic model_step(input int p, input int cdf);
    int free;
    int hc;
    int vc;
    bit fire_ok;
    hc = int'(hcount);
    vc = int'(vcount);
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_act[p][i] = 0; m_x[p][i] = 0; m_y[p][i] = 0;
      end
      m_cd[p] = 0; m_ack[p] = 0; m_drop[p] = 0; m_pix[p] = 0;
      return;
    end
    free = -1;
    for (int i = 3; i >= 0; i--) if (!m_act[p][i]) free = i;
    m_pix[p] = 0;
    for (int i = 0; i < 4; i++)
      if (m_act[p][i] && hc >= m_x[p][i] && hc < m_x[p][i] + 4 &&
          vc >= m_y[p][i] && vc < m_y[p][i] + 16) m_pix[p] = 1;
    fire_ok   = fire_req && (m_cd[p] == 0);
    m_ack[p]  = fire_ok && (free >= 0);
    m_drop[p] = fire_ok && (free < 0);
    for (int i = 0; i < 4; i++) begin
      if (m_ack[p] && i == free) begin
        m_act[p][i] = 1;
        m_x[p][i]   = (int'(fire_x) > 1276) ? 1276 : int'(fire_x);
        m_y[p][i]   = int'(fire_y);
      end else if (hit_valid && int'(hit_idx) == i) begin
        m_act[p][i] = 0;
      end else if (frame_tick && m_act[p][i]) begin
        if (m_y[p][i] < 16) m_act[p][i] = 0;
        else m_y[p][i] = m_y[p][i] - 16;
      end
    end
    if (m_ack[p]) m_cd[p] = cdf;
    else if (frame_tick && m_cd[p] > 0) m_cd[p] = m_cd[p] - 1;
  endtask

  task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, actual, expected);
    end
  endtask

  task automatic check_pool(input string tag, input int p, input logic [3:0] act,
                            input logic [43:0] bxv, input logic [39:0] byv,
                            input logic ack, input logic drop, input logic pix);
    logic [3:0]  ea;
    logic [43:0] ex;
    logic [39:0] ey;
    for (int i = 0; i < 4; i++) begin
      ea[i]          = m_act[p][i];
      ex[i*11 +: 11] = m_x[p][i][10:0];
      ey[i*10 +: 10] = m_y[p][i][9:0];
    end
    chk({tag, ".active"}, 64'(act), 64'(ea));
    chk({tag, ".bx"}, 64'(bxv), 64'(ex));
    chk({tag, ".by"}, 64'(byv), 64'(ey));
    chk({tag, ".ack"}, 64'(ack), 64'(m_ack[p]));
    chk({tag, ".drop"}, 64'(drop), 64'(m_drop[p]));
    chk({tag, ".pix"}, 64'(pix), 64'(m_pix[p]));
  endtask

  task automatic cycle();
    model_step(0, 0);
    model_step(1, 8);
    @(posedge clk);
    @(negedge clk);
    check_pool("A", 0, a_active, a_bx, a_by, a_ack, a_drop, a_pix);
    check_pool("B", 1, b_active, b_bx, b_by, b_ack, b_drop, b_pix);
  endtask

  task automatic do_reset();
    rst = 1; frame_tick = 0; fire_req = 0; hit_valid = 0;
    cycle();
    rst = 0;
  endtask

  task automatic tick();
    frame_tick = 1;
    cycle();
    frame_tick = 0;
  endtask

  task automatic fire1(input int x, input int y);
    fire_x = 11'(x); fire_y = 10'(y); fire_req = 1;
    cycle();
    fire_req = 0;
  endtask

  function automatic logic [10:0] a_x(input int i); return a_bx[i*11 +: 11]; endfunction
  function automatic logic [9:0]  a_y(input int i); return a_by[i*10 +: 10]; endfunction

  typedef struct packed {
    logic [10:0] hc;
    logic [9:0]  vc;
    logic        pix;
  } pix_vec_t;

  pix_vec_t pv[10];

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
    $fatal(1);
  end

  initial begin
    int ticks;
    int got;
    int b_drops;
    int k;

    // Bullet spawned at x=1279 clamps to 1276, top at y=100.
    pv[0] = '{hc: 11'd1275, vc: 10'd100, pix: 1'b0};
    pv[1] = '{hc: 11'd1276, vc: 10'd100, pix: 1'b1};
    pv[2] = '{hc: 11'd1279, vc: 10'd100, pix: 1'b1};
    pv[3] = '{hc: 11'd1279, vc: 10'd115, pix: 1'b1};
    pv[4] = '{hc: 11'd1279, vc: 10'd116, pix: 1'b0};
    pv[5] = '{hc: 11'd1276, vc: 10'd99,  pix: 1'b0};
    pv[6] = '{hc: 11'd1278, vc: 10'd108, pix: 1'b1};
    pv[7] = '{hc: 11'd1280, vc: 10'd108, pix: 1'b0};
    pv[8] = '{hc: 11'd0,    vc: 10'd0,   pix: 1'b0};
    pv[9] = '{hc: 11'd1277, vc: 10'd110, pix: 1'b1};

    // Reset state and first shot.
    rst = 1;
    cycle();
    chk("rst.active", 64'(a_active), 64'd0);
    chk("rst.bx", 64'(a_bx), 64'd0);
    chk("rst.by", 64'(a_by), 64'd0);
    chk("rst.ack", 64'(a_ack), 64'd0);
    chk("rst.drop", 64'(a_drop), 64'd0);
    chk("rst.pix", 64'(a_pix), 64'd0);
    rst = 0;
    fire1(600, 680);
    chk("t1.ack", 64'(a_ack), 64'd1);
    chk("t1.active", 64'(a_active), 64'd1);
    chk("t1.bx0", 64'(a_x(0)), 64'd600);
    chk("t1.by0", 64'(a_y(0)), 64'd680);
    cycle();
    for (int i = 0; i < 3; i++) begin
      tick();
      cycle();
    end
    chk("t1.by0_after3", 64'(a_y(0)), 64'd632);

    // Fill the pool, then overflow.
    do_reset();
    fire_x = 11'd100; fire_y = 10'd600; fire_req = 1;
    for (int n = 1; n <= 5; n++) begin
      cycle();
      chk("t2.ack", 64'(a_ack), (n <= 4) ? 64'd1 : 64'd0);
      chk("t2.drop", 64'(a_drop), (n == 5) ? 64'd1 : 64'd0);
      chk("t2.active", 64'(a_active), (n <= 4) ? 64'((1 << n) - 1) : 64'd15);
      chk("t2.b_drop", 64'(b_drop), 64'd0);
    end
    fire_req = 0;

    // Cooldown: holding fire_req, pool B re-acks exactly 8 frames later.
    do_reset();
    fire_x = 11'd300; fire_y = 10'd700; fire_req = 1;
    cycle();
    chk("t3.first_ack", 64'(b_ack), 64'd1);
    ticks = 0; got = -1; b_drops = 0;
    for (int t = 0; t < 12 && got < 0; t++) begin
      tick();
      ticks++;
      if (b_ack && got < 0) got = ticks - 1;
      b_drops += int'(b_drop);
      for (int j = 0; j < 2; j++) begin
        cycle();
        if (b_ack && got < 0) got = ticks;
        b_drops += int'(b_drop);
      end
    end
    fire_req = 0;
    chk("t3.ticks_between_acks", 64'(got), 64'd8);
    chk("t3.drops", 64'(b_drops), 64'd0);

    // Top edge: no wrap-around.
    do_reset();
    fire1(50, 20);
    tick();
    chk("t4.by0", 64'(a_y(0)), 64'd4);
    chk("t4.active1", 64'(a_active), 64'd1);
    tick();
    chk("t4.active2", 64'(a_active), 64'd0);
    chk("t4.by0_hold", 64'(a_y(0)), 64'd4);

    // Hit coinciding with a tick, then slot reuse.
    do_reset();
    fire_x = 11'd200; fire_y = 10'd500; fire_req = 1;
    for (int i = 0; i < 3; i++) cycle();
    fire_req = 0;
    hit_valid = 1; hit_idx = 2'd1; frame_tick = 1;
    cycle();
    hit_valid = 0; frame_tick = 0;
    chk("t5.active", 64'(a_active), 64'h5);
    chk("t5.by0", 64'(a_y(0)), 64'd484);
    chk("t5.by2", 64'(a_y(2)), 64'd484);
    chk("t5.b_active", 64'(b_active), 64'h1);
    fire1(220, 400);
    chk("t5.reuse_active", 64'(a_active), 64'h7);
    chk("t5.reuse_bx1", 64'(a_x(1)), 64'd220);
    chk("t5.reuse_by1", 64'(a_y(1)), 64'd400);

    // Right-edge clamp and pixel window, then reset mid-flight.
    do_reset();
    fire1(1279, 100);
    chk("t6.bx0", 64'(a_x(0)), 64'd1276);
    chk("t6.by0", 64'(a_y(0)), 64'd100);
    for (int i = 0; i < 10; i++) begin
      hcount = pv[i].hc; vcount = pv[i].vc;
      cycle();
      chk("t6.pix", 64'(a_pix), 64'(pv[i].pix));
    end
    rst = 1; fire_req = 1;
    cycle();
    chk("t6.rst_active", 64'(a_active), 64'd0);
    chk("t6.rst_b_active", 64'(b_active), 64'd0);
    chk("t6.rst_ack", 64'(a_ack), 64'd0);
    rst = 0; fire_req = 0;
    cycle();
    chk("t6.no_pending_ack", 64'(a_ack), 64'd0);

    // Randomised traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst        = ($urandom_range(0, 63) == 0);
      frame_tick = ($urandom_range(0, 5) == 0);
      fire_req   = ($urandom_range(0, 2) == 0);
      fire_x     = 11'($urandom);
      fire_y     = 10'($urandom);
      hit_valid  = ($urandom_range(0, 3) == 0);
      hit_idx    = 2'($urandom);
      k          = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0 && m_act[0][k]) begin
        hcount = 11'(m_x[0][k] + int'($urandom_range(0, 6)) - 1);
        vcount = 10'(m_y[0][k] + int'($urandom_range(0, 18)) - 1);
      end else begin
        hcount = 11'($urandom);
        vcount = 10'($urandom);
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
